seq_alu_core: RTL
=================

// Module: seq_alu_core
// PURPOSE
//   Parametrised multi-cycle ALU with a start/busy/valid handshake and an accumulator chaining mode.
//   Successor to the fixed 4-bit calculator core: operand width is a parameter, shifts are added,
//   and an iterative shift-add multiplier can be compiled in. Sits between the pin-level wrapper
//   (operand/opcode capture) and the result/flag output mux.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=4); result is 2*WIDTH bits wide
// PORTS
//   clk       in   1        single system clock, rising edge
//   rst_n     in   1        asynchronous, active-low reset
//   start     in   1        request; sampled only in IDLE
//   op        in   3        opcode, latched with start
//   a         in   WIDTH    operand A, latched with start
//   b         in   WIDTH    operand B, latched with start
//   acc_sel   in   1        1: use result[WIDTH-1:0] as A instead of port a
//   result    out  2*WIDTH  last completed result, held until next completion
//   zero      out  1        result[WIDTH-1:0]==0
//   carry     out  1        ADD carry-out / SUB borrow / last bit shifted out
//   overflow  out  1        signed overflow (ADD/SUB); upper half nonzero (MUL)
//   valid     out  1        one-cycle pulse: result/flags updated this cycle
//   busy      out  1        high from accept edge until completion edge
//   err       out  1        op unsupported in this build; pulses with valid
// BEHAVIOUR
//   - Reset (async, any state): FSM->IDLE; result, zero, carry, overflow, valid, busy, err all 0.
//   - Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
//   - FSM: IDLE -> EXEC (single-cycle ops) or IDLE -> MUL (WIDTH iterations) -> back to IDLE.
//   - Accept: start=1 in IDLE at edge k latches op, A (a or acc), b; busy=1 from edge k.
//   - Latency: non-MUL ops complete at edge k+1; MUL completes at edge k+WIDTH.
//     At completion edge: result/flags registered, valid=1 for exactly one cycle, busy=0, FSM=IDLE.
//   - start while busy is ignored (no queueing, no error). start in the valid cycle is accepted
//     (back-to-back, one op per 2 cycles min for single-cycle ops).
//   - Width rules: ADD result = {0.., carry, sum[WIDTH-1:0]}; SUB = A-B mod 2^WIDTH, carry=A<B
//     (unsigned); logic ops upper half 0, carry=0, overflow=0.
//   - SHL/SHR shift amount = b[$clog2(WIDTH)-1:0]; amount 0 gives A, carry=0; upper half 0.
//   - MUL: unsigned full 2*WIDTH product; carry=0.
//   - acc_sel with no prior completion uses 0 (result reset value).
//   - Reset asserted mid-MUL aborts silently; no valid pulse follows.
// CONFIGURATION
//   SEQ_ALU_MUL_EN defined: op 111 runs the iterative multiplier as above.
//   Not defined: multiplier absent; op 111 completes at k+1 with result=0, flags=0, err=1.
//   err is 0 for all other opcodes in both builds.
// STRUCTURE
//   Package seq_alu_pkg: opcode enum (OP_ADD..OP_MUL), FSM state enum (IDLE, EXEC, MUL).
//   Sub-module seq_alu_mul_iter: shift-add multiplier, ports clk, rst_n, load, a, b, done,
//   product; instantiated only under SEQ_ALU_MUL_EN. Core FSM, single-cycle ALU, flags in top.
// TESTING (WIDTH=8, MUL build unless noted)
//   ADD a=FF b=01 -> at k+1: result=0100, zero=1, carry=1, overflow=0, valid pulse 1 cycle.
//   SUB a=80 b=01 -> result=007F, overflow=1, carry=0; SUB a=01 b=02 -> 00FF, carry=1.
//   MUL a=FF b=FF -> busy 8 cycles, at k+8 result=FE01, overflow=1; start pulses mid-op ignored.
//   ADD a=05 b=03 (->0008), then acc_sel=1 SHL b=02 in valid cycle -> 0020 at next edge.
//   Reset asserted at k+3 of MUL -> all outputs 0 immediately, no valid; next ADD works.
//   Non-MUL build: op=111 a=03 b=04 -> at k+1 result=0000, err=1, valid=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_alu_pkg : opcode and FSM state encodings for the sequential ALU core   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// +----------------------------------------------------------------------------+
// | seq_alu_if : request/result bundle between the operand wrapper and core    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 acc_sel;
  logic [2*WIDTH-1:0]   result;
  logic                 zero;
  logic                 carry;
  logic                 overflow;
  logic                 valid;
  logic                 busy;
  logic                 err;

  modport master (
    output start, op, a, b, acc_sel,
    input  result, zero, carry, overflow, valid, busy, err
  );

  modport slave (
    input  start, op, a, b, acc_sel,
    output result, zero, carry, overflow, valid, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu_mul_iter.sv
// +----------------------------------------------------------------------------+
// | seq_alu_mul_iter : iterative shift-add unsigned multiplier                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 load,
  input  wire logic [WIDTH-1:0]     a,
  input  wire logic [WIDTH-1:0]     b,
  output logic                      done,
  output logic [2*WIDTH-1:0]        product
);

  localparam int                CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH);

  logic                 r_run;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_mplier;

  // Bit 0 is folded into the load cycle so the product is final after
  // WIDTH-1 further edges and the core can register it on edge k+WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_run    <= 1'b1;
      r_cnt    <= CNT_W'(1);
      r_prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      r_mplier <= b >> 1;
    end else if (r_run) begin
      if (r_cnt == C_LAST) begin
        r_run <= 1'b0;
      end else begin
        r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign done    = r_run && (r_cnt == C_LAST);
  assign product = r_prod;

endmodule

`default_nettype wire

// File: rtl/seq_alu_core.sv
// +----------------------------------------------------------------------------+
// | seq_alu_core : multi-cycle ALU, start/busy/valid handshake, acc chaining   |
// | Optional multiplier: define SEQ_ALU_MUL_EN.              Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_alu_core #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  seq_alu_if.slave    bus
);
  import seq_alu_pkg::*;

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               r_state;
  state_e               w_next;
  op_e                  r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_zero;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_valid;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_done;
  logic [WIDTH-1:0]     w_a_sel;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH:0]       w_shr;
  logic [SH_W-1:0]      w_amt;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_err;
  logic                 w_zero;
`ifdef SEQ_ALU_MUL_EN
  logic                 w_mul_load;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_product;
`endif

  assign w_a_sel = bus.acc_sel ? r_result[WIDTH-1:0] : bus.a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    w_mul_load = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = EXEC;
`ifdef SEQ_ALU_MUL_EN
          if (op_e'(bus.op) == OP_MUL) begin
            w_next     = MUL;
            w_mul_load = 1'b1;
          end
`endif
        end
      end
      EXEC: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      MUL: begin
`ifdef SEQ_ALU_MUL_EN
        if (w_mul_done) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
`else
        w_next = IDLE;
`endif
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  seq_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_mul_load),
    .a       (w_a_sel),
    .b       (bus.b),
    .done    (w_mul_done),
    .product (w_product)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= op_e'(bus.op);
      r_a  <= w_a_sel;
      r_b  <= bus.b;
    end
  end

  // Extra guard bit on the shifters captures the last bit shifted out.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = r_a - r_b;
  assign w_amt  = r_b[SH_W-1:0];
  assign w_shl  = {1'b0, r_a} << w_amt;
  assign w_shr  = {r_a, 1'b0} >> w_amt;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_sum};
        w_carry = w_sum[WIDTH];
        w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = {{WIDTH{1'b0}}, w_diff};
        w_carry = (r_a < r_b);
        w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND: w_res = {{WIDTH{1'b0}}, r_a & r_b};
      OP_OR:  w_res = {{WIDTH{1'b0}}, r_a | r_b};
      OP_XOR: w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
      OP_SHL: begin
        w_res   = {{WIDTH{1'b0}}, w_shl[WIDTH-1:0]};
        w_carry = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res   = {{WIDTH{1'b0}}, w_shr[WIDTH:1]};
        w_carry = w_shr[0];
      end
      OP_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        w_res = w_product;
        w_ovf = |w_product[2*WIDTH-1:WIDTH];
`else
        w_err = 1'b1;
`endif
      end
      default: w_err = 1'b1;
    endcase
  end

  // An unsupported op reports all flags clear, including zero.
  assign w_zero = ~w_err & (w_res[WIDTH-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= w_done;
      r_err   <= w_done & w_err;
      if (w_done) begin
        r_result <= w_res;
        r_zero   <= w_zero;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.result   = r_result;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
  assign bus.valid    = r_valid;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state != IDLE);

endmodule

`default_nettype wire
